// File: rtl/lbp_pkg.sv
// Shared image geometry, widths and host FSM state encoding for the LBP image host.
package lbp_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;
    localparam int CNT_W  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } lbp_state_e;
endpackage

// File: rtl/lbp_img_ram.sv
// Image-sized RAM: one synchronous write port, one asynchronous read port and
// one registered read port whose output register clears on reset.
module lbp_img_ram
    import lbp_pkg::*;
#(
    parameter int DEPTH = lbp_pkg::IMG_W * lbp_pkg::IMG_H,
    parameter int AW    = lbp_pkg::ADDR_W,
    parameter int DW    = lbp_pkg::PIX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [DEPTH];

    // Storage itself is never cleared; only the read register follows reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_b <= '0;
        end else if (re_b) begin
            rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/lbp_img_host.sv
// LBP image host: loads a gray image, serves it to an LBP consumer, collects results
// and offers registered readout. Define LBP_HOST_CHECK_EN to enable the protocol checker (err).
module lbp_img_host
    import lbp_pkg::*;
#(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [PIX_W-1:0]  load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [PIX_W-1:0]  gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [PIX_W-1:0]  lbp_data,
    input  logic              finish,
    output logic              done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err,
    output lbp_state_e        state_dbg
);
    localparam int NPIX = IMG_W * IMG_H;

    // Handshake: a pixel transfers on a rising edge where load_valid && load_ready;
    // load_ready is high for the whole LOAD state and never depends on load_valid.
    lbp_state_e        state, next_state;
    logic [ADDR_W-1:0] load_cnt;
    logic              load_fire;
    logic              load_last;
    logic              serve;
    logic              res_we;
    logic              rd_en;
    logic [PIX_W-1:0]  gray_rd;
    logic [PIX_W-1:0]  gray_rd_b_unused;
    logic [PIX_W-1:0]  res_rd_a_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = ST_LOAD;
            ST_LOAD:  if (load_last) next_state = ST_SERVE;
            ST_SERVE: if (finish) next_state = ST_DONE;
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == ST_LOAD);
        serve      = (state == ST_SERVE);
        done       = (state == ST_DONE);
        load_fire  = load_valid && load_ready;
        load_last  = load_fire && (load_cnt == ADDR_W'(NPIX - 1));
        res_we     = lbp_valid && serve;
        rd_en      = rd_req && done;
    end

    assign state_dbg = state;
    assign gray_data = (gray_req && serve) ? gray_rd : '0;

    // The count parks on the final address once the image is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt   <= '0;
            gray_ready <= 1'b0;
            wr_count   <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (load_fire && !load_last) begin
                load_cnt <= load_cnt + 1'b1;
            end
            gray_ready <= (next_state == ST_SERVE);
            if (res_we && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + 1'b1;
            end
            rd_valid <= rd_en;
        end
    end

    lbp_img_ram #(.DEPTH(NPIX), .AW(ADDR_W), .DW(PIX_W)) u_gray_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (load_fire),
        .waddr   (load_cnt),
        .wdata   (load_data),
        .raddr_a (gray_addr),
        .rdata_a (gray_rd),
        .re_b    (1'b0),
        .raddr_b (load_cnt),
        .rdata_b (gray_rd_b_unused)
    );

    lbp_img_ram #(.DEPTH(NPIX), .AW(ADDR_W), .DW(PIX_W)) u_result_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (res_we),
        .waddr   (lbp_addr),
        .wdata   (lbp_data),
        .raddr_a (lbp_addr),
        .rdata_a (res_rd_a_unused),
        .re_b    (rd_en),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

`ifdef LBP_HOST_CHECK_EN
    localparam int COL_W = $clog2(IMG_W);

    logic [ADDR_W-1:0] lbp_row;
    logic [COL_W-1:0]  lbp_col;
    logic              on_border;
    logic              violation;

    // Border pixels have no full neighbourhood, so their LBP code must be zero.
    always_comb begin
        lbp_row   = lbp_addr >> COL_W;
        lbp_col   = lbp_addr[COL_W-1:0];
        on_border = (lbp_col == '0) || (lbp_col == COL_W'(IMG_W - 1)) ||
                    (lbp_row == '0) || (lbp_row == ADDR_W'(IMG_H - 1));
        violation = (gray_req && !serve) || (lbp_valid && !serve) ||
                    (lbp_valid && on_border && (lbp_data != '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lbp_img_host.sv
// Directed testbench for lbp_img_host: load, serve, result write, readout, reset and err.
module tb_lbp_img_host;
    import lbp_pkg::*;

    logic              clk;
    logic              reset;
    logic              load_valid;
    logic [PIX_W-1:0]  load_data;
    logic              load_ready;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [PIX_W-1:0]  lbp_data;
    logic              finish;
    logic              done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  wr_count;
    logic              err;
    lbp_state_e        state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    lbp_img_host dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_count   (wr_count),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (state_dbg !== ST_IDLE || load_ready !== 1'b0 || gray_ready !== 1'b0 ||
            done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 ||
            wr_count !== 15'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: state=%0d load_ready=%b gray_ready=%b done=%b rd_valid=%b rd_data=%h wr_count=%0d err=%b, required idle/0s",
                     tag, state_dbg, load_ready, gray_ready, done, rd_valid, rd_data, wr_count, err);
        end
    endtask

    // driver: pixels first..last-1, value addr[7:0] (or inverted), optional 5-cycle stall
    task automatic drive_pixels(input int first, input int last, input bit inv, input int stall_at);
        int t;
        logic [ADDR_W-1:0] a;
        for (int i = first; i < last; i++) begin
            if (i == stall_at) begin
                load_valid = 1'b0;
                repeat (5) step();
                n_tests++;
                if (state_dbg !== ST_LOAD || gray_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold: state=%0d gray_ready=%b, required LOAD/0", state_dbg, gray_ready);
                end
            end
            a = ADDR_W'(i);
            load_valid = 1'b1;
            load_data  = inv ? ~a[7:0] : a[7:0];
            t = 0;
            while (!load_ready && t < 20) begin
                step();
                t++;
            end
            if (!load_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_ready_timeout: load_ready=%b, required 1", load_ready);
                load_valid = 1'b0;
                return;
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        check_reset_values("reset_state");
        reset = 1'b0;
        step();
        n_tests++;
        if (state_dbg !== ST_LOAD || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_to_load: state=%0d load_ready=%b, required LOAD/1", state_dbg, load_ready);
        end
    endtask

    task automatic test_load();
        drive_pixels(0, 16383, 1'b0, 8000);
        n_tests++;
        if (state_dbg !== ST_LOAD || gray_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_16383: state=%0d gray_ready=%b, required LOAD/0", state_dbg, gray_ready);
        end
        drive_pixels(16383, 16384, 1'b0, -1);
        n_tests++;
        if (state_dbg !== ST_SERVE || gray_ready !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_16384: state=%0d gray_ready=%b load_ready=%b, required SERVE/1/0",
                     state_dbg, gray_ready, load_ready);
        end
    endtask

    task automatic test_gray_read(input bit inv);
        logic [ADDR_W-1:0] addrs [3];
        logic [7:0] exp;
        addrs[0] = 14'd129;
        addrs[1] = 14'd0;
        addrs[2] = 14'd16383;
        gray_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gray_addr = addrs[k];
            exp = inv ? ~addrs[k][7:0] : addrs[k][7:0];
            #1;
            n_tests++;
            if (gray_data !== exp || gray_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL gray_read addr=%0d: gray_data=%h gray_ready=%b, required %h/1",
                         addrs[k], gray_data, gray_ready, exp);
            end
        end
        gray_req = 1'b0;
        #1;
        n_tests++;
        if (gray_data !== 8'h00) begin
            n_fail++;
            $display("FAIL gray_no_req: gray_data=%h, required 00", gray_data);
        end
    endtask

    task automatic test_lbp_write_finish();
        lbp_valid = 1'b1;
        lbp_addr  = 14'd130;
        lbp_data  = 8'h5A;
        step();
        lbp_addr  = 14'd131;
        lbp_data  = 8'hC3;
        finish    = 1'b1;
        step();
        lbp_valid = 1'b0;
        finish    = 1'b0;
        n_tests++;
        if (state_dbg !== ST_DONE || done !== 1'b1 || wr_count !== 15'd2 || gray_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_done: state=%0d done=%b wr_count=%0d gray_ready=%b, required DONE/1/2/0",
                     state_dbg, done, wr_count, gray_ready);
        end
        // writes and reads in DONE are ignored
        lbp_valid = 1'b1;
        lbp_addr  = 14'd130;
        lbp_data  = 8'hFF;
        gray_req  = 1'b1;
        gray_addr = 14'd129;
        #1;
        n_tests++;
        if (gray_data !== 8'h00) begin
            n_fail++;
            $display("FAIL done_gray: gray_data=%h, required 00", gray_data);
        end
        step();
        lbp_valid = 1'b0;
        gray_req  = 1'b0;
        n_tests++;
        if (wr_count !== 15'd2 || state_dbg !== ST_DONE) begin
            n_fail++;
            $display("FAIL done_ignore_write: wr_count=%0d state=%0d, required 2/DONE", wr_count, state_dbg);
        end
    endtask

    task automatic test_back_to_back_readout();
        rd_req  = 1'b1;
        rd_addr = 14'd130;
        step();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL readout_130: rd_valid=%b rd_data=%h, required 1/5a", rd_valid, rd_data);
        end
        rd_addr = 14'd131;
        step();
        rd_req = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL readout_131: rd_valid=%b rd_data=%h, required 1/c3", rd_valid, rd_data);
        end
        step();
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL readout_idle: rd_valid=%b, required 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        drive_pixels(0, 1000, 1'b1, -1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid_load");
        step();
        reset = 1'b0;
        drive_pixels(0, 16384, 1'b1, -1);
        n_tests++;
        if (state_dbg !== ST_SERVE) begin
            n_fail++;
            $display("FAIL reload_serve: state=%0d, required SERVE", state_dbg);
        end
        test_gray_read(1'b1);
    endtask

    task automatic test_err();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean: err=%b, required 0", err);
        end
        lbp_valid = 1'b1;
        lbp_addr  = 14'd128;
        lbp_data  = 8'h01;
        step();
        lbp_valid = 1'b0;
        lbp_data  = 8'h00;
`ifdef LBP_HOST_CHECK_EN
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
        repeat (3) step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
`else
        repeat (3) step();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_tied: err=%b, required 0", err);
        end
`endif
        // result memory survives reset: 131 still holds the first run's value
        finish = 1'b1;
        step();
        finish  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 14'd131;
        step();
        rd_req = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || wr_count !== 15'd1) begin
            n_fail++;
            $display("FAIL result_kept: rd_valid=%b rd_data=%h wr_count=%0d, required 1/c3/1",
                     rd_valid, rd_data, wr_count);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        gray_req   = 1'b0;
        gray_addr  = '0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;

        test_reset();
        test_load();
        test_gray_read(1'b0);
        test_lbp_write_finish();
        test_back_to_back_readout();
        test_reset_mid_load();
        test_err();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
